// File: rtl/pulse_scheduler.sv
// Round-robin pulse scheduler: request edges become fixed-width pulses on one output.
// Optional overflow flags are built when PULSE_SCHED_OVF_EN is defined.
module pulse_scheduler #(
    parameter int N_REQ   = 4,
    parameter int PULSE_W = 1,
    parameter int GAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    output logic                     pulse_out,
    output logic [$clog2(N_REQ)-1:0] pulse_id,
    output logic [N_REQ-1:0]         pending,
    output logic                     busy
`ifdef PULSE_SCHED_OVF_EN
    ,
    input  logic                     ovf_clr,
    output logic [N_REQ-1:0]         ovf
`endif
);

    localparam int IW   = $clog2(N_REQ);
    localparam int MAXV = (PULSE_W > GAP) ? PULSE_W : GAP;
    localparam int CW   = $clog2(MAXV + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_GAP
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] pend_d;
    logic [N_REQ-1:0] edge_w;
    logic [N_REQ-1:0] gnt_mask;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    ptr_d;
    logic [IW-1:0]    id_q;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    cand;
    logic             gnt_any;
    logic             grant;

    assign edge_w  = req & ~req_q;
    assign grant   = (state_q == S_IDLE) && gnt_any;
    assign ptr_d   = IW'((int'(gnt_idx) + 1) % N_REQ);
    assign pend_d  = (pend_q & ~gnt_mask) | edge_w;
    assign pending = pend_q;

    // Pick the first pending requester at or above the pointer, wrapping.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_any && pend_q[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // One-hot clear mask for the requester granted this cycle.
    always_comb begin
        gnt_mask = '0;
        if (grant) begin
            gnt_mask[gnt_idx] = 1'b1;
        end
    end

    // Edge capture; a new edge on the granted line survives its own clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= '0;
            pend_q <= '0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
        end
    end

    // Scheduling FSM with a down-counter reloaded on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        state_q <= S_PULSE;
                        cnt_q   <= CW'(PULSE_W - 1);
                        id_q    <= gnt_idx;
                        ptr_q   <= ptr_d;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        if (GAP == 0) begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= S_GAP;
                            cnt_q   <= CW'(GAP - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Registered outputs follow the FSM state one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_out <= 1'b0;
            pulse_id  <= '0;
            busy      <= 1'b0;
        end else begin
            pulse_out <= (state_q == S_PULSE);
            pulse_id  <= (state_q == S_PULSE) ? id_q : '0;
            busy      <= (state_q != S_IDLE);
        end
    end

`ifdef PULSE_SCHED_OVF_EN
    logic [N_REQ-1:0] ovf_q;
    logic [N_REQ-1:0] ovf_d;

    assign ovf_d = ovf_clr ? '0
                 : (ovf_q | (edge_w & pend_q & ~gnt_mask));
    assign ovf   = ovf_q;

    // Sticky overflow flags; a clear beats a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule

// File: doc/pulse_scheduler.md
PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 SHALL have parameter PULSE_W, default 1, output pulse width in clock cycles (1..255).
REQ-003 SHALL have parameter GAP, default 1, mandatory idle cycles after each pulse (0..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_REQ  level request per requester; each rising edge is one pulse event.
REQ-007 SHALL have port pulse_out  output  1  shared scheduled pulse, high for exactly PULSE_W cycles per event.
REQ-008 SHALL have port pulse_id  output  clog2(N_REQ)  index of requester served; valid while pulse_out=1, else 0.
REQ-009 SHALL have port pending  output  N_REQ  registered per-requester event-pending flags.
REQ-010 SHALL have port busy  output  1  high in PULSE and GAP states.

Function
REQ-011 SHALL register req into req_q each cycle; edge[i] = req[i] & ~req_q[i].
REQ-012 SHALL set pending[i] at the clock edge where edge[i]=1; multiple events while pending merge into one.
REQ-013 SHALL implement FSM IDLE, PULSE, GAP; IDLE->PULSE when any pending bit is set, PULSE->GAP (or IDLE if GAP=0) after PULSE_W cycles, GAP->IDLE after GAP cycles.
REQ-014 SHALL, on IDLE->PULSE, grant the first set pending bit at or above rr pointer (wrapping N_REQ-1->0), clear that bit, latch its index to pulse_id, set pointer to index+1 mod N_REQ.
REQ-015 SHALL hold pulse_out=1 exactly in PULSE state; pulse_out rises 2 clock edges after the edge first sampling req[i]=1 when IDLE and nothing else pending.
REQ-016 SHALL space consecutive pulse starts by exactly PULSE_W+GAP+1 cycles when requests remain pending.
REQ-017 SHALL keep pending[i] set if edge[i] coincides with its grant (new event survives clear).
REQ-018 SHALL ignore req changes during PULSE/GAP except for pending capture; a pulse in progress is never truncated or extended.
REQ-019 SHALL use a down-counter of width clog2(max(PULSE_W,GAP)+1) reloaded on each state entry.

Reset
REQ-020 SHALL, while rst_n=0, force state=IDLE, pending=0, req_q=0, rr pointer=0, counter=0, pulse_out=0, pulse_id=0, busy=0, ovf=0.
REQ-021 SHALL abort any pulse immediately on rst_n assertion; a req held high across reset release counts as one event.

Configuration
REQ-022 SHALL, with macro PULSE_SCHED_OVF_EN defined, add output ovf (N_REQ) and input ovf_clr (1); ovf[i] sets when edge[i]=1 while pending[i]=1 and not granted that cycle, and is sticky until ovf_clr=1 (clear wins over set same cycle).
REQ-023 SHALL, without PULSE_SCHED_OVF_EN, omit ovf and ovf_clr ports and silently merge extra events.

Verification (N_REQ=4, PULSE_W=2, GAP=1)
REQ-024 SHALL cover single event: req[1] 0->1 sampled at edge k -> pulse_out=1 after edges k+2,k+3, pulse_id=1, busy through k+4, pending[1]=0 after k+2.
REQ-025 SHALL cover simultaneous events: req[0],req[2] rise same edge from reset -> pulse id 0 then id 2, starts 4 cycles apart.
REQ-026 SHALL cover round-robin wrap: pointer=3, pending={0,3} -> id 3 served then id 0.
REQ-027 SHALL cover event during own grant: req[2] re-edge on grant cycle -> pending[2] remains 1, second id-2 pulse follows.
REQ-028 SHALL cover reset mid-pulse: rst_n=0 in first PULSE cycle -> pulse_out=0 immediately, all pending=0, state IDLE after release.
REQ-029 SHALL cover overflow (PULSE_SCHED_OVF_EN): two req[3] edges while pending[3]=1 -> ovf[3]=1 until ovf_clr pulse, then 0.
